// File: rtl/cpr_ram_multi.sv
// N-port write-first RAM with registered read addresses and a checkpoint/restore engine
// that streams the whole memory out (dump) or in (restore) over valid/ready handshakes.
module cpr_ram_multi #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned NUM_PORTS  = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] ADDR,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] DIN,
  input  logic [NUM_PORTS-1:0]            WE,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] DOUT,
  input  logic                            cpr_ctrl_read,
  input  logic                            cpr_ctrl_write,
  input  logic [DATA_WIDTH-1:0]           ext_wdata,
  input  logic                            ext_wvalid,
  output logic                            ext_wready,
  output logic [DATA_WIDTH-1:0]           ext_rdata,
  output logic                            ext_rvalid,
  input  logic                            ext_rready,
  output logic                            cpr_busy,
  output logic                            cpr_done
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StDump, StRestore} state_e;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [NUM_PORTS];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  pend_q, pend_d;    // dump read issued, data lands next cycle
  logic                  last_q, last_d;    // final word already loaded into rdata
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;

  assign cpr_busy   = (state_q != StIdle);
  assign ext_wready = (state_q == StRestore);
  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;
  assign cpr_done   = done_q;

  // Later ports override earlier ones on a shared address; restore writes come last.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (WE[i] && !cpr_busy) begin
        mem[ADDR[i*ADDR_WIDTH +: ADDR_WIDTH]] <= DIN[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (state_q == StRestore && ext_wvalid) begin
      mem[cnt_q] <= ext_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_q[i] <= ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    DOUT = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      DOUT[i*DATA_WIDTH +: DATA_WIDTH] = mem[addr_q[i]];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    last_d   = last_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cpr_ctrl_read) begin
          state_d  = StDump;
          cnt_d    = '0;
          pend_d   = 1'b0;
          last_d   = 1'b0;
          rvalid_d = 1'b0;
        end else if (cpr_ctrl_write) begin
          state_d = StRestore;
          cnt_d   = '0;
        end
      end
      StDump: begin
        if (rvalid_q && ext_rready) begin
          rvalid_d = 1'b0;
        end
        if (pend_q) begin
          rdata_d  = mem[cnt_q];
          rvalid_d = 1'b1;
          pend_d   = 1'b0;
          if (cnt_q == LAST_ADDR) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end else if (!last_q && (!rvalid_q || ext_rready)) begin
          pend_d = 1'b1;
        end
        if (rvalid_q && ext_rready && last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRestore: begin
        if (ext_wvalid) begin
          if (cnt_q == LAST_ADDR) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      last_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_cpr_ram_multi.sv
// Directed bench for cpr_ram_multi: table of user-port vectors plus hand-written
// dump, restore and reset-abort sequences, checked against a 16-word model.
module tb_cpr_ram_multi;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  ADDR;
  logic [63:0] DIN;
  logic [1:0]  WE;
  logic [63:0] DOUT;
  logic        cpr_ctrl_read, cpr_ctrl_write;
  logic [31:0] ext_wdata;
  logic        ext_wvalid, ext_wready;
  logic [31:0] ext_rdata;
  logic        ext_rvalid, ext_rready;
  logic        cpr_busy, cpr_done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mem [16];

  cpr_ram_multi #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_PORTS(2)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .DIN(DIN), .WE(WE), .DOUT(DOUT),
    .cpr_ctrl_read(cpr_ctrl_read), .cpr_ctrl_write(cpr_ctrl_write),
    .ext_wdata(ext_wdata), .ext_wvalid(ext_wvalid), .ext_wready(ext_wready),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_rready(ext_rready),
    .cpr_busy(cpr_busy), .cpr_done(cpr_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  a0;
    logic [31:0] d0;
    logic        we0;
    logic [3:0]  a1;
    logic [31:0] d1;
    logic        we1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [3:0] a0, logic [31:0] d0, logic we0, logic [3:0] a1,
                              logic [31:0] d1, logic we1, logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.a0 = a0; v.d0 = d0; v.we0 = we0;
    v.a1 = a1; v.d1 = d1; v.we1 = we1;
    v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  function automatic logic [31:0] init_val(int a);
    return (a < 8) ? 32'(a) : 32'(100 + a - 8);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic read_all(input string tag);
    for (int k = 0; k < 16; k++) begin
      ADDR = {4'(15 - k), 4'(k)};
      WE   = 2'b00;
      tick();
      chk($sformatf("%s_p0_a%0d", tag, k), DOUT[31:0], exp_mem[k]);
      chk($sformatf("%s_p1_a%0d", tag, 15 - k), DOUT[63:32], exp_mem[15 - k]);
    end
  endtask

  task automatic run_dump(input bit rnd, input bit both, input bit user_we);
    int          idx = 0;
    int          dones = 0;
    int          busy_bad = 0;
    int          stall_bad = 0;
    bit          prev_stall = 0;
    bit          rdy;
    logic [31:0] prev_data = '0;
    cpr_ctrl_read  = 1'b1;
    cpr_ctrl_write = both;
    tick();
    cpr_ctrl_read  = 1'b0;
    cpr_ctrl_write = 1'b0;
    chk("dump_busy_start", 32'(cpr_busy), 32'd1);
    chk("dump_not_restore", 32'(ext_wready), 32'd0);
    if (user_we) begin
      WE   = 2'b11;
      ADDR = {4'd9, 4'd2};
      DIN  = {32'hDEAD0001, 32'hDEAD0000};
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ext_rready = rdy;
      if (prev_stall && (!ext_rvalid || ext_rdata !== prev_data)) stall_bad++;
      if (!cpr_busy) busy_bad++;
      if (ext_rvalid && rdy) begin
        if (idx < 16) chk($sformatf("dump_word%0d", idx), ext_rdata, exp_mem[idx]);
        idx++;
      end
      prev_stall = ext_rvalid && !rdy;
      prev_data  = ext_rdata;
      tick();
      if (cpr_done) begin
        dones++;
        WE = 2'b00;
        break;
      end
    end
    ext_rready = 1'b0;
    WE = 2'b00;
    chk("dump_word_count", 32'(idx), 32'd16);
    chk("dump_busy_end", 32'(cpr_busy), 32'd0);
    chk("dump_rvalid_end", 32'(ext_rvalid), 32'd0);
    chk("dump_busy_held", 32'(busy_bad), 32'd0);
    chk("dump_stall_stable", 32'(stall_bad), 32'd0);
    tick();
    if (cpr_done) dones++;
    tick();
    if (cpr_done) dones++;
    chk("dump_done_once", 32'(dones), 32'd1);
  endtask

  initial begin
    int k;
    int early;
    int n;
    RST = 1'b1; ADDR = '0; DIN = '0; WE = '0;
    cpr_ctrl_read = 1'b0; cpr_ctrl_write = 1'b0;
    ext_wdata = '0; ext_wvalid = 1'b0; ext_rready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(cpr_busy), 32'd0);
    chk("rst_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rst_wready", 32'(ext_wready), 32'd0);
    chk("rst_done", 32'(cpr_done), 32'd0);
    chk("rst_rdata", ext_rdata, 32'd0);
    RST = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(4'(i), 32'(i), 1, 4'(8 + i), 32'(100 + i), 1, 32'(i), 32'(100 + i)));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(4'(i), 0, 0, 4'(15 - i), 0, 0, init_val(i), init_val(15 - i)));
    vecs.push_back(mk(4'd5, 32'hAA, 1, 4'd5, 32'hBB, 1, 32'hBB, 32'hBB));
    vecs.push_back(mk(4'd5, 0, 0, 4'd5, 0, 0, 32'hBB, 32'hBB));
    vecs.push_back(mk(4'd3, 32'h333, 1, 4'd3, 0, 0, 32'h333, 32'h333));
    vecs.push_back(mk(4'd5, 0, 0, 4'd5, 32'd5, 1, 32'd5, 32'd5));
    vecs.push_back(mk(4'd3, 32'd3, 1, 4'd3, 0, 0, 32'd3, 32'd3));
    foreach (vecs[i]) begin
      ADDR = {vecs[i].a1, vecs[i].a0};
      DIN  = {vecs[i].d1, vecs[i].d0};
      WE   = {vecs[i].we1, vecs[i].we0};
      tick();
      chk($sformatf("vec%0d_p0", i), DOUT[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_p1", i), DOUT[63:32], vecs[i].e1);
    end
    WE = 2'b00;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);

    // Dump with ready held high while user ports try to write.
    run_dump(0, 0, 1);
    read_all("post_dump");

    // Restore with gapped valid.
    cpr_ctrl_write = 1'b1;
    tick();
    cpr_ctrl_write = 1'b0;
    chk("restore_wready", 32'(ext_wready), 32'd1);
    chk("restore_busy", 32'(cpr_busy), 32'd1);
    k = 0;
    early = 0;
    for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
      ext_wvalid = (cyc % 3 != 1);
      ext_wdata  = 32'h1000 + 32'(k);
      tick();
      if (ext_wvalid) k++;
      if (cpr_done && k < 16) early++;
    end
    ext_wvalid = 1'b0;
    chk("restore_words", 32'(k), 32'd16);
    chk("restore_early_done", 32'(early), 32'd0);
    chk("restore_done", 32'(cpr_done), 32'd1);
    chk("restore_wready_end", 32'(ext_wready), 32'd0);
    chk("restore_busy_end", 32'(cpr_busy), 32'd0);
    tick();
    chk("restore_done_drop", 32'(cpr_done), 32'd0);
    for (int i = 0; i < 16; i++) exp_mem[i] = 32'h1000 + 32'(i);
    read_all("post_restore");

    // Both requests together pick dump; random ready exercises stalls.
    run_dump(1, 1, 0);

    // Reset after five accepted words aborts; next dump restarts at address 0.
    cpr_ctrl_read = 1'b1;
    tick();
    cpr_ctrl_read = 1'b0;
    ext_rready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 100 && n < 5; cyc++) begin
      if (ext_rvalid) n++;
      tick();
    end
    chk("abort_words", 32'(n), 32'd5);
    RST = 1'b1;
    tick();
    chk("abort_busy", 32'(cpr_busy), 32'd0);
    chk("abort_rvalid", 32'(ext_rvalid), 32'd0);
    chk("abort_done", 32'(cpr_done), 32'd0);
    RST = 1'b0;
    ext_rready = 1'b0;
    tick();
    chk("abort_no_done", 32'(cpr_done), 32'd0);
    run_dump(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpr_ram_multi.md
Name: cpr_ram_multi

Overview:
- Parametrised N-port, write-first, registered-address RAM with a checkpoint/restore (CPR) engine.
- The CPR engine streams the full memory out (dump) or in (restore) over a valid/ready port, so that host software can snapshot and reload accelerator state.
- Instantiated in place of two-port CPR RAMs in generated accelerator tops; the user ports are driven by the design FSM.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 14, address width; depth DEPTH = 2**ADDR_WIDTH
NUM_PORTS, 2, number of user read/write ports (>=1)

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  synchronous active-high reset
ADDR  in  NUM_PORTS*ADDR_WIDTH  user addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
DIN  in  NUM_PORTS*DATA_WIDTH  user write data, packed the same way
WE  in  NUM_PORTS  user write enables
DOUT  out  NUM_PORTS*DATA_WIDTH  user read data
cpr_ctrl_read  in  1  dump request pulse
cpr_ctrl_write  in  1  restore request pulse
ext_wdata  in  DATA_WIDTH  restore data
ext_wvalid  in  1  restore data valid
ext_wready  out  1  restore data accepted
ext_rdata  out  DATA_WIDTH  dump data
ext_rvalid  out  1  dump data valid
ext_rready  in  1  dump data consumed
cpr_busy  out  1  CPR engine active
cpr_done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - FSM goes to IDLE; CPR address counter = 0.
  - ext_rvalid, ext_wready, cpr_busy and cpr_done = 0; ext_rdata = 0.
  - Per-port delayed addresses = 0.
  - Memory contents are not cleared.
  - Reset mid-dump or mid-restore aborts the operation with no cpr_done. Words already restored stay written.
- User ports:
  - Port i read: DOUT_i = mem[delayed ADDR_i], where the address is registered every cycle, so data is valid 1 cycle after ADDR_i is presented.
  - Port i write: on an edge with WE_i=1, mem[ADDR_i] <= DIN_i.
  - Write-first: a read of an address written on the same edge returns the new data on the next cycle.
  - Multiple ports writing the same address on the same edge: the highest-index port wins.
  - While cpr_busy=1, all user writes are dropped; user reads still operate.
- FSM states: IDLE, DUMP, RESTORE.
- IDLE:
  - cpr_ctrl_read=1 -> DUMP.
  - cpr_ctrl_write=1 -> RESTORE.
  - Both high: DUMP wins and the write request is discarded.
  - On entry to either state: counter = 0, cpr_busy = 1 from the next cycle.
- DUMP:
  - Reads mem[counter] with 1-cycle read latency into an output register.
  - A read is issued only when no read is in flight AND (ext_rvalid=0 OR ext_rready=1 this cycle).
  - Throughput is 1 word per 2 cycles when ext_rready is held high.
  - ext_rdata/ext_rvalid are held stable while ext_rvalid=1 and ext_rready=0.
  - After word DEPTH-1 is accepted (ext_rvalid & ext_rready): pulse cpr_done for 1 cycle, cpr_busy = 0, go to IDLE.
  - The counter does not wrap past DEPTH-1.
- RESTORE:
  - ext_wready = 1.
  - Each ext_wvalid=1 cycle writes mem[counter] <= ext_wdata and increments counter.
  - After word DEPTH-1 is written: ext_wready = 0, cpr_done pulses, go to IDLE.
  - A CPR write takes precedence over every user port; user writes are already dropped in this state.
- cpr_ctrl_read and cpr_ctrl_write are ignored while busy.
- A cpr_done pulse occurs only on completion.

Test Plan:
- (ADDR_WIDTH=4, NUM_PORTS=2.) Port0 writes 0..7 at addr 0..7, port1 writes 100..107 at addr 8..15 concurrently -> reading each address returns the written value 1 cycle after the address is presented.
- Port0 and port1 both write addr 5 on the same edge, with 0xAA and 0xBB -> mem[5]=0xBB. Read-during-write of addr 3 -> new value seen next cycle.
- Pulse cpr_ctrl_read with ext_rready=1 -> 16 words 0..7, 100..107 are dumped in order; cpr_done pulses once; cpr_busy is high throughout. User WE during the dump -> memory unchanged.
- Dump with ext_rready toggled randomly -> no word lost or duplicated; ext_rdata is stable while stalled.
- Pulse cpr_ctrl_write and feed 16 words 0x1000+k with gapped ext_wvalid -> mem[k]=0x1000+k; cpr_done pulses after word 15. Simultaneous cpr_ctrl_read and cpr_ctrl_write -> DUMP runs.
- Assert RST after 5 dumped words -> cpr_busy, ext_rvalid and cpr_done go to 0 next cycle. A new dump started afterwards begins at address 0.
